letter_input_validator: RTL and testbench
=========================================

Name: letter_input_validator

Overview:
- Front-end stage of the input-validation path. Turns the raw 5-bit letter switches and the mechanical "enter" button into a clean, validated letter plus a single-cycle load strobe.
- Drives the letter register directly: LET feeds its letter input and LD feeds its load input.
- Synchronises and debounces the button, range-checks the switch code (A=0 … Z=25), and issues exactly one LD per physical press.
- Invalid codes raise ERR instead of loading.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive synchronised samples required to accept a press or a release (5 ms at 100 MHz); legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived, not overridden).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  synchronous, active-low reset.
- SW  input  5  raw letter code from the switches; must be stable while BTN is held.
- BTN  input  1  raw enter button, asynchronous and bouncy, active-high.
- LET  output  5  last accepted letter, 0..25.
- LD  output  1  one-cycle strobe, high for exactly one CLK cycle per accepted letter.
- ERR  output  1  high after a press whose SW code was >25; cleared by the next valid accept.
- BUSY  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (RST_N=0 at an edge):
  - LET=0, LD=0, ERR=0, BUSY=0.
  - Sync flops cleared, counter=0, FSM=IDLE.
  - Reset dominates all other events.
- Synchroniser: 2-flop chain BTN→s1→btn_s. Only btn_s is used by the FSM.
- FSM states, transitions evaluated each edge:
  - IDLE: btn_s=1 → DEB_PRESS, cnt<=1; otherwise stay.
  - DEB_PRESS:
    - btn_s=0 → IDLE, cnt<=0. This is a bounce; no LD, ERR unchanged.
    - btn_s=1 and cnt≠DEBOUNCE_CYCLES-1 → cnt<=cnt+1.
    - btn_s=1 and cnt=DEBOUNCE_CYCLES-1 → fire, then → HELD.
  - Fire, when SW≤25: LET<=SW, LD<=1, ERR<=0.
  - Fire, when SW≥26: LET unchanged, LD stays 0, ERR<=1.
  - HELD: btn_s=0 → DEB_RELEASE, cnt<=1; otherwise stay. No further LD while held, so there is no auto-repeat.
  - DEB_RELEASE:
    - btn_s=1 → HELD, cnt<=0.
    - btn_s=0 and cnt=DEBOUNCE_CYCLES-1 → IDLE.
    - Otherwise cnt<=cnt+1.
- LD is a registered output. It is forced to 0 on every edge that is not a valid fire.
- Latency, taking edge 0 as the first edge that samples BTN=1 with BTN clean: LD is high from edge DEBOUNCE_CYCLES+1 to edge DEBOUNCE_CYCLES+2.
- SW is sampled only on the fire edge. Changes to SW at any other time have no effect.
- LET holds its value indefinitely between accepts.
- ERR is sticky:
  - Set only by an invalid fire.
  - Cleared only by a valid fire or by reset.
- BUSY = (state≠IDLE), combinational from the state register.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- Button held through reset deassertion: the FSM restarts in IDLE and treats it as a new press, requiring the full sync plus debounce before LD.
- Release glitch shorter than DEBOUNCE_CYCLES while in HELD: returns to HELD, no second LD.
- Press shorter than DEBOUNCE_CYCLES samples: no LD, no ERR change, back to IDLE.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: SW=7, BTN rises before edge 0 and held 20 cycles → LD high exactly edge 5→6; LET=7; ERR=0; BUSY=1 until 4 cycles after btn_s falls.
- Bounce: BTN toggles 1,0,1,0 one cycle each, then held high; SW=25 → exactly one LD, 4 btn_s-high samples after the final rise; LET=25.
- Invalid: SW=30, clean press → no LD, LET keeps previous value, ERR=1. Next press with SW=0 → LD pulse, LET=0, ERR=0.
- Hold and glitch: press SW=3, hold 50 cycles, insert 2-cycle BTN low glitch mid-hold → single LD total; FSM returns to HELD.
- Reset mid-debounce: RST_N=0 for 1 edge while in DEB_PRESS with cnt=2 → all outputs 0, IDLE. BTN still high → LD appears 5 edges after first post-reset edge sampling BTN.
- Back-to-back: two full press/release cycles with SW=1 then SW=2 → two LD pulses, LET=1 then LET=2; SW changes while HELD are ignored.

Source files
------------

// File: rtl/letter_input_validator.sv
// rtl/letter_input_validator.sv - debounced letter-entry front end
// Synchronises the enter button and issues one range-checked load strobe per press.
module letter_input_validator #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] SW,
  input  logic       BTN,
  output logic [4:0] LET,
  output logic       LD,
  output logic       ERR,
  output logic       BUSY
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] LAST_LETTER = 5'd25;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, btn_s_q;
  logic [4:0]       let_q, let_d;
  logic             ld_q, ld_d;
  logic             err_q, err_d;
  logic             fire;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      let_q   <= '0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= BTN;
      btn_s_q <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      let_q   <= let_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  // The counter holds how many consecutive stable samples have been seen in a debounce state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = DEB_PRESS;
          cnt_d   = CNT_W'(1);
        end
      end
      DEB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          fire    = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = DEB_RELEASE;
          cnt_d   = CNT_W'(1);
        end
      end
      DEB_RELEASE: begin
        if (btn_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    let_d = let_q;
    ld_d  = 1'b0;
    err_d = err_q;
    if (fire) begin
      if (SW <= LAST_LETTER) begin
        let_d = SW;
        ld_d  = 1'b1;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign BUSY = (state_q != IDLE);
  assign LET  = let_q;
  assign LD   = ld_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_letter_input_validator.sv
// tb/tb_letter_input_validator.sv - self-checking bench for letter_input_validator
// Expected letters are queued at press time and popped whenever LD is seen.
module tb_letter_input_validator;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] SW;
  logic       BTN;
  logic [4:0] LET;
  logic       LD;
  logic       ERR;
  logic       BUSY;

  int n_pass  = 0;
  int n_total = 0;
  int ld_count = 0;
  logic prev_ld = 1'b0;
  logic [4:0] exp_q[$];

  letter_input_validator #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .SW   (SW),
    .BTN  (BTN),
    .LET  (LET),
    .LD   (LD),
    .ERR  (ERR),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every LD pulse must match the oldest queued letter and last one cycle.
  always @(negedge CLK) begin
    if (LD === 1'b1) begin
      logic [4:0] exp;
      ld_count = ld_count + 1;
      n_total = n_total + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_ld: LET=%0d, no load expected", LET);
      end else begin
        exp = exp_q.pop_front();
        if (LET !== exp) $display("FAIL sb_let: got %0d expected %0d", LET, exp);
        else n_pass = n_pass + 1;
      end
      n_total = n_total + 1;
      if (prev_ld === 1'b1) $display("FAIL sb_ld_width: LD high %0d cycles in a row, expected 1", 2);
      else n_pass = n_pass + 1;
    end
    prev_ld = LD;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (BUSY !== 1'b0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    n_total++;
    if (BUSY !== 1'b0) $display("FAIL %s_idle_timeout: BUSY=%b expected 0 within 50 cycles", name, BUSY);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    BTN   = 1'b0;
    SW    = 5'd0;
    tick(3);
    n_total++; if (LET !== 5'd0) $display("FAIL reset_let: got %0d expected 0", LET); else n_pass++;
    n_total++; if (LD !== 1'b0) $display("FAIL reset_ld: got %b expected 0", LD); else n_pass++;
    n_total++; if (ERR !== 1'b0) $display("FAIL reset_err: got %b expected 0", ERR); else n_pass++;
    n_total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", BUSY); else n_pass++;
    RST_N = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_press();
    SW = 5'd7;
    exp_q.push_back(5'd7);
    BTN = 1'b1;
    // Negedge k follows edge k-1; LD must be visible only after edge DEB+1.
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      n_total++;
      if (LD !== (k == DEB + 2)) $display("FAIL clean_ld_timing: cycle %0d LD=%b expected %b", k, LD, (k == DEB + 2));
      else n_pass++;
    end
    n_total++; if (LET !== 5'd7) $display("FAIL clean_let: got %0d expected 7", LET); else n_pass++;
    n_total++; if (ERR !== 1'b0) $display("FAIL clean_err: got %b expected 0", ERR); else n_pass++;
    BTN = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      n_total++;
      if (BUSY !== (k <= DEB + 1)) $display("FAIL clean_busy_release: cycle %0d BUSY=%b expected %b", k, BUSY, (k <= DEB + 1));
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int ld0;
    ld0 = ld_count;
    SW = 5'd25;
    exp_q.push_back(5'd25);
    BTN = 1'b1; tick(1);
    BTN = 1'b0; tick(1);
    BTN = 1'b1; tick(1);
    BTN = 1'b0; tick(1);
    BTN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      n_total++;
      if (LD !== (k == DEB + 2)) $display("FAIL bounce_ld_timing: cycle %0d LD=%b expected %b", k, LD, (k == DEB + 2));
      else n_pass++;
    end
    BTN = 1'b0;
    wait_idle("bounce");
    n_total++; if (ld_count - ld0 !== 1) $display("FAIL bounce_ld_count: got %0d expected 1", ld_count - ld0); else n_pass++;
    n_total++; if (LET !== 5'd25) $display("FAIL bounce_let: got %0d expected 25", LET); else n_pass++;
  endtask

  task automatic test_invalid();
    int ld0;
    ld0 = ld_count;
    SW = 5'd30;
    BTN = 1'b1;
    tick(12);
    n_total++; if (ld_count - ld0 !== 0) $display("FAIL invalid_no_ld: got %0d loads expected 0", ld_count - ld0); else n_pass++;
    n_total++; if (LET !== 5'd25) $display("FAIL invalid_let_kept: got %0d expected 25", LET); else n_pass++;
    n_total++; if (ERR !== 1'b1) $display("FAIL invalid_err_set: got %b expected 1", ERR); else n_pass++;
    BTN = 1'b0;
    wait_idle("invalid");
    n_total++; if (ERR !== 1'b1) $display("FAIL invalid_err_sticky: got %b expected 1", ERR); else n_pass++;
    SW = 5'd0;
    exp_q.push_back(5'd0);
    BTN = 1'b1;
    tick(12);
    n_total++; if (ld_count - ld0 !== 1) $display("FAIL invalid_recover_ld: got %0d expected 1", ld_count - ld0); else n_pass++;
    n_total++; if (LET !== 5'd0) $display("FAIL invalid_recover_let: got %0d expected 0", LET); else n_pass++;
    n_total++; if (ERR !== 1'b0) $display("FAIL invalid_err_cleared: got %b expected 0", ERR); else n_pass++;
    BTN = 1'b0;
    wait_idle("invalid2");
  endtask

  task automatic test_hold_glitch();
    int ld0;
    logic busy_ok;
    ld0 = ld_count;
    busy_ok = 1'b1;
    SW = 5'd3;
    exp_q.push_back(5'd3);
    BTN = 1'b1;
    tick(20);
    BTN = 1'b0;
    tick(2);
    BTN = 1'b1;
    for (int k = 0; k < 28; k++) begin
      @(negedge CLK);
      if (BUSY !== 1'b1) busy_ok = 1'b0;
    end
    n_total++; if (busy_ok !== 1'b1) $display("FAIL glitch_busy: BUSY dropped during hold, expected stay 1"); else n_pass++;
    n_total++; if (ld_count - ld0 !== 1) $display("FAIL glitch_ld_count: got %0d expected 1", ld_count - ld0); else n_pass++;
    BTN = 1'b0;
    wait_idle("glitch");
    n_total++; if (ld_count - ld0 !== 1) $display("FAIL glitch_ld_final: got %0d expected 1", ld_count - ld0); else n_pass++;
    n_total++; if (LET !== 5'd3) $display("FAIL glitch_let: got %0d expected 3", LET); else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    SW = 5'd5;
    exp_q.push_back(5'd5);
    BTN = 1'b1;
    tick(4);
    RST_N = 1'b0;
    tick(1);
    n_total++; if (LET !== 5'd0) $display("FAIL midrst_let: got %0d expected 0", LET); else n_pass++;
    n_total++; if (LD !== 1'b0) $display("FAIL midrst_ld: got %b expected 0", LD); else n_pass++;
    n_total++; if (ERR !== 1'b0) $display("FAIL midrst_err: got %b expected 0", ERR); else n_pass++;
    n_total++; if (BUSY !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", BUSY); else n_pass++;
    RST_N = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      n_total++;
      if (LD !== (k == DEB + 2)) $display("FAIL midrst_ld_timing: cycle %0d LD=%b expected %b", k, LD, (k == DEB + 2));
      else n_pass++;
    end
    BTN = 1'b0;
    wait_idle("midrst");
  endtask

  task automatic test_back_to_back();
    int ld0;
    ld0 = ld_count;
    SW = 5'd1;
    exp_q.push_back(5'd1);
    BTN = 1'b1;
    tick(10);
    SW = 5'd20;
    tick(5);
    n_total++; if (LET !== 5'd1) $display("FAIL b2b_let1: got %0d expected 1", LET); else n_pass++;
    BTN = 1'b0;
    wait_idle("b2b1");
    SW = 5'd2;
    exp_q.push_back(5'd2);
    BTN = 1'b1;
    tick(10);
    SW = 5'd31;
    tick(5);
    n_total++; if (LET !== 5'd2) $display("FAIL b2b_let2: got %0d expected 2", LET); else n_pass++;
    n_total++; if (ERR !== 1'b0) $display("FAIL b2b_err: got %b expected 0", ERR); else n_pass++;
    BTN = 1'b0;
    wait_idle("b2b2");
    n_total++; if (ld_count - ld0 !== 2) $display("FAIL b2b_ld_count: got %0d expected 2", ld_count - ld0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_invalid();
    test_hold_glitch();
    test_reset_mid_debounce();
    test_back_to_back();
    tick(3);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d loads outstanding, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
